fifo_mc_rr_pe: RTL

Single-clock, multi-channel FIFO for PE ingress: NCH independent write channels, each with its own 2^ADDRSIZE-deep buffer, drained through one shared first-word-fall-through output port by a round-robin arbiter. Each write channel keeps the toggle-ack protocol used by our PE FIFOs, so upstream PEs reuse their existing ack-edge logic. It sits between the PE array write ports and the single consumer stage.

---
 rtl/fifo_mc_rr_pe.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fifo_mc_rr_pe.sv
// Multi-channel toggle-ack FIFO for PE ingress: NCH write channels drained through one
// round-robin, first-word-fall-through output port. Optional almost-full: FIFO_MC_PE_AFULL_EN.
module fifo_mc_rr_pe #(
  parameter  int DATASIZE  = 8,
  parameter  int ADDRSIZE  = 4,
  parameter  int NCH       = 4,
  parameter  int AFULL_LVL = 12,
  localparam int CHW       = $clog2(NCH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NCH*DATASIZE-1:0]      wdata,
  input  logic [NCH-1:0]               winc,
  output logic [NCH-1:0]               wfull,
  output logic [NCH-1:0]               ack,
  output logic [NCH*(ADDRSIZE+1)-1:0]  count,
`ifdef FIFO_MC_PE_AFULL_EN
  output logic [NCH-1:0]               afull,
`endif
  output logic [DATASIZE-1:0]          rdata,
  output logic [CHW-1:0]               rch,
  output logic                         rvalid,
  input  logic                         rready
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] FULL_CNT = (ADDRSIZE+1)'(DEPTH);

  logic [DATASIZE-1:0] mem  [NCH][DEPTH];
  logic [ADDRSIZE-1:0] wptr [NCH];
  logic [ADDRSIZE-1:0] rptr [NCH];
  logic [ADDRSIZE:0]   cnt  [NCH];
  logic [NCH-1:0]      ack_q;
  logic [NCH-1:0]      nonempty;
  logic [NCH-1:0]      wr_en;
  logic [NCH-1:0]      pop_en;
  logic [CHW-1:0]      last_grant;
  logic [CHW-1:0]      lock_ch;
  logic [CHW-1:0]      grant;
  logic [CHW-1:0]      idx;
  logic                found;
  logic                lock;
  logic                pop;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign nonempty[i] = (cnt[i] != '0);
    assign wfull[i]    = (cnt[i] == FULL_CNT);
    // A full channel drops the write even when it is popped in the same cycle.
    assign wr_en[i]    = winc[i] && !wfull[i];
    assign pop_en[i]   = pop && (rch == CHW'(i));
    assign count[i*(ADDRSIZE+1) +: (ADDRSIZE+1)] = cnt[i];
`ifdef FIFO_MC_PE_AFULL_EN
    assign afull[i]    = (cnt[i] >= (ADDRSIZE+1)'(AFULL_LVL));
`endif
  end

  assign ack    = ack_q;
  assign rvalid = |nonempty;
  assign pop    = rvalid && rready;

  // Round-robin search starting one past the last served channel.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = CHW'((int'(last_grant) + k) % NCH);
      if (!found && nonempty[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // A presented but unaccepted word pins the grant so rch/rdata stay stable.
  assign rch   = !rvalid ? '0 : (lock ? lock_ch : grant);
  assign rdata = rvalid ? mem[rch][rptr[rch]] : '0;

  // NOTE: storage has no reset; only pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (wr_en[i]) mem[i][wptr[i]] <= wdata[i*DATASIZE +: DATASIZE];
    end
  end

  // NOTE: all state uses non-blocking assignments so every channel sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
      ack_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_en[i]) begin
          wptr[i]  <= wptr[i] + 1'b1;
          ack_q[i] <= ~ack_q[i];
        end
        if (pop_en[i]) rptr[i] <= rptr[i] + 1'b1;
        case ({wr_en[i], pop_en[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= CHW'(NCH-1);
      lock       <= 1'b0;
      lock_ch    <= '0;
    end else if (pop) begin
      last_grant <= rch;
      lock       <= 1'b0;
    end else if (rvalid) begin
      lock       <= 1'b1;
      lock_ch    <= rch;
    end
  end

endmodule
